// File: rtl/data_mem_sized.sv
// data_mem_sized
// Byte-addressed, word-organised data memory for the MIPS datapath.
// Supports byte/half/word loads and stores with sign or zero extension and
// byte-lane write masking. A req/ready/done handshake with a configurable
// access latency lets the pipeline stall on memory. Misaligned, out-of-range
// and reserved-size accesses are reported through err and never modify the
// array.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   req          access request, accepted when ready=1 on a rising edge
//   write_en     1 = store, 0 = load (sampled with req)
//   size         00 byte, 01 half, 10 word, 11 reserved
//   unsigned_ld  1 = zero-extend loads, 0 = sign-extend
//   addr         byte address
//   write_data   store data, right-justified
//   ready        block can accept a request this cycle
//   done         one-cycle completion pulse
//   read_data    extended load result, valid while done=1 (held afterwards)
//   err          access faulted, valid while done=1 (held afterwards)
module data_mem_sized #(
    parameter int ADDR_SIZE  = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic                  write_en,
    input  logic [1:0]            size,
    input  logic                  unsigned_ld,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  err
);

    localparam int IDX_W  = (ADDR_SIZE > 1) ? $clog2(ADDR_SIZE) : 1;
    localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int WIDX_W = ADDR_WIDTH - 2;

    // Parameter sanity checks, caught at elaboration time.
    if (DATA_WIDTH != 32) begin : gen_bad_data_width
        $error("data_mem_sized: DATA_WIDTH must be 32");
    end
    if (LATENCY < 1) begin : gen_bad_latency
        $error("data_mem_sized: LATENCY must be >= 1");
    end
    if (ADDR_WIDTH < IDX_W + 2) begin : gen_bad_addr_width
        $error("data_mem_sized: ADDR_WIDTH too small for ADDR_SIZE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    enterDone;
    logic                    accept;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              size_q;
    logic                    we_q;
    logic                    uns_q;
    logic [DATA_WIDTH-1:0]   wdata_q;

    logic [DATA_WIDTH-1:0]   read_data_q;
    logic                    err_q;

    logic [DATA_WIDTH-1:0]   mem [ADDR_SIZE];

    // Access view seen by the commit logic.
    logic [ADDR_WIDTH-1:0]   accAddr;
    logic [1:0]              accSize;
    logic                    accWe;
    logic                    accUns;
    logic [DATA_WIDTH-1:0]   accWdata;

    logic [WIDX_W-1:0]       wordIdx;
    logic [IDX_W-1:0]        memIdx;
    logic                    fault;
    logic                    commitWrite;
    logic [DATA_WIDTH-1:0]   oldWord;
    logic [DATA_WIDTH-1:0]   newWord;
    logic [DATA_WIDTH-1:0]   laneData;
    logic [3:0]              laneMask;
    logic [7:0]              byteSel;
    logic [15:0]             halfSel;
    logic [DATA_WIDTH-1:0]   loadVal;

    assign accept = req && (state_q == IDLE);
    assign ready  = (state_q == IDLE);
    assign done   = (state_q == DONE);
    assign read_data = read_data_q;
    assign err       = err_q;

    // With LATENCY=1 the commit edge is the accept edge, so the request
    // inputs are used directly; otherwise the latched copy is used.
    assign accAddr  = (state_q == IDLE) ? addr        : addr_q;
    assign accSize  = (state_q == IDLE) ? size        : size_q;
    assign accWe    = (state_q == IDLE) ? write_en    : we_q;
    assign accUns   = (state_q == IDLE) ? unsigned_ld : uns_q;
    assign accWdata = (state_q == IDLE) ? write_data  : wdata_q;

    // Next-state logic. The counter is loaded with LATENCY-1 on accept and
    // DONE is entered on the edge where it decrements to zero.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        enterDone = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_d   = DONE;
                        enterDone = 1'b1;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    enterDone = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q  <= '0;
            size_q  <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= addr;
            size_q  <= size;
            we_q    <= write_en;
            uns_q   <= unsigned_ld;
            wdata_q <= write_data;
        end
    end

    assign wordIdx = accAddr[ADDR_WIDTH-1:2];
    assign memIdx  = wordIdx[IDX_W-1:0];
    assign oldWord = mem[memIdx];

    assign fault = (accSize == 2'b11)
                 || ((accSize == 2'b01) && accAddr[0])
                 || ((accSize == 2'b10) && (accAddr[1:0] != 2'b00))
                 || (wordIdx >= WIDX_W'(ADDR_SIZE));

    // Store merge: replicate the store data across lanes and pick the
    // lanes selected by size and the low address bits.
    always_comb begin
        laneMask = 4'b0000;
        laneData = '0;
        newWord  = oldWord;
        case (accSize)
            2'b00: begin
                laneMask = 4'b0001 << accAddr[1:0];
                laneData = {4{accWdata[7:0]}};
            end
            2'b01: begin
                laneMask = accAddr[1] ? 4'b1100 : 4'b0011;
                laneData = {2{accWdata[15:0]}};
            end
            2'b10: begin
                laneMask = 4'b1111;
                laneData = accWdata;
            end
            default: begin
                laneMask = 4'b0000;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            if (laneMask[i]) begin
                newWord[8*i +: 8] = laneData[8*i +: 8];
            end
        end
    end

    // Load extraction and extension.
    always_comb begin
        byteSel = oldWord[{accAddr[1:0], 3'b000} +: 8];
        halfSel = accAddr[1] ? oldWord[31:16] : oldWord[15:0];
        case (accSize)
            2'b00:   loadVal = accUns ? {24'd0, byteSel} : {{24{byteSel[7]}}, byteSel};
            2'b01:   loadVal = accUns ? {16'd0, halfSel} : {{16{halfSel[15]}}, halfSel};
            2'b10:   loadVal = oldWord;
            default: loadVal = '0;
        endcase
    end

    // A store colliding with reset on its commit edge must be dropped.
    assign commitWrite = enterDone && accWe && !fault && !rst;

    // Memory array is intentionally not reset.
    always_ff @(posedge clk) begin
        if (commitWrite) begin
            mem[memIdx] <= newWord;
        end
    end

    // Result registers update on the edge entering DONE and hold afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_data_q <= '0;
            err_q       <= 1'b0;
        end else if (enterDone) begin
            err_q       <= fault;
            read_data_q <= (fault || accWe) ? '0 : loadVal;
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Testbench for data_mem_sized: one instance with LATENCY=1 and one with
// LATENCY=3, checked against a byte-array reference model.
module tb_data_mem_sized;

    logic        clk = 1'b0;
    logic        rstA, rstB, reqA, reqB;
    logic        weI, unsI;
    logic [1:0]  sizeI;
    logic [31:0] addrI, wdataI;
    logic        readyA, doneA, errA;
    logic        readyB, doneB, errB;
    logic [31:0] rdA, rdB;

    int total = 0;
    int bad   = 0;

    // Byte-addressed reference memories, one per instance.
    logic [7:0] mdl [2][1024];

    always #5 clk = ~clk;

    data_mem_sized #(.ADDR_SIZE(256), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) dutA (
        .clk(clk), .rst(rstA), .req(reqA), .write_en(weI), .size(sizeI),
        .unsigned_ld(unsI), .addr(addrI), .write_data(wdataI),
        .ready(readyA), .done(doneA), .read_data(rdA), .err(errA)
    );

    data_mem_sized #(.ADDR_SIZE(256), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(3)) dutB (
        .clk(clk), .rst(rstB), .req(reqB), .write_en(weI), .size(sizeI),
        .unsigned_ld(unsI), .addr(addrI), .write_data(wdataI),
        .ready(readyB), .done(doneB), .read_data(rdB), .err(errB)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    // Reference model: applies the access to the byte array and returns
    // the expected err and read_data.
    function automatic void modelAccess(input int d, input logic we, input logic [1:0] sz,
                                        input logic uns, input logic [31:0] a, input logic [31:0] wd,
                                        output logic expErr, output logic [31:0] expRd);
        int n;
        logic [31:0] v;
        expErr = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0)
                 || ((a >> 2) >= 32'd256);
        expRd = 32'd0;
        if (expErr) return;
        n = 1 << sz;
        if (we) begin
            for (int i = 0; i < n; i++) mdl[d][int'(a) + i] = wd[8*i +: 8];
        end else begin
            v = 32'd0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[d][int'(a) + i];
            if (n == 1) v = uns ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
            if (n == 2) v = uns ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
            expRd = v;
        end
    endfunction

    // One full handshake on instance d, checked cycle by cycle against the model.
    task automatic applyStimulus(input int d, input logic we, input logic [1:0] sz, input logic uns,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 output logic [31:0] gotRd, output logic gotErr);
        int lat;
        int cyc;
        logic dn;
        logic expErr;
        logic [31:0] expRd;
        lat = (d == 0) ? 1 : 3;
        @(negedge clk);
        weI = we; sizeI = sz; unsI = uns; addrI = a; wdataI = wd;
        if (d == 0) reqA = 1'b1; else reqB = 1'b1;
        checkOutput("readyIdle", (d == 0) ? readyA : readyB, 32'd1);
        @(posedge clk);
        cyc = 0;
        dn = 1'b0;
        while (!dn && cyc < 20) begin
            @(negedge clk);
            cyc++;
            dn = (d == 0) ? doneA : doneB;
            checkOutput("readyLow", (d == 0) ? readyA : readyB, 32'd0);
        end
        checkOutput("latency", cyc, lat);
        reqA = 1'b0;
        reqB = 1'b0;
        modelAccess(d, we, sz, uns, a, wd, expErr, expRd);
        gotRd  = (d == 0) ? rdA : rdB;
        gotErr = (d == 0) ? errA : errB;
        checkOutput("err", gotErr, expErr);
        checkOutput("rdata", gotRd, expRd);
        @(negedge clk);
        checkOutput("doneFall", (d == 0) ? doneA : doneB, 32'd0);
        checkOutput("readyBack", (d == 0) ? readyA : readyB, 32'd1);
        checkOutput("rdataHold", (d == 0) ? rdA : rdB, expRd);
        checkOutput("errHold", (d == 0) ? errA : errB, expErr);
    endtask

    task automatic randomAccess(input int d);
        logic [31:0] a, rd;
        logic e;
        if ($urandom_range(0, 9) == 0) a = 32'h400 + $urandom_range(0, 255);
        else a = $urandom_range(0, 16 * 4 + 3);
        applyStimulus(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom, rd, e);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic e;
        rstA = 1'b1; rstB = 1'b1; reqA = 1'b0; reqB = 1'b0;
        weI = 1'b0; unsI = 1'b0; sizeI = 2'd0; addrI = '0; wdataI = '0;
        repeat (3) @(negedge clk);
        checkOutput("rstReadyA", readyA, 1); checkOutput("rstDoneA", doneA, 0);
        checkOutput("rstErrA", errA, 0);     checkOutput("rstRdA", rdA, 0);
        checkOutput("rstReadyB", readyB, 1); checkOutput("rstDoneB", doneB, 0);
        rstA = 1'b0; rstB = 1'b0;

        // Known contents for the region the random traffic touches.
        for (int i = 0; i <= 16; i++) begin
            applyStimulus(0, 1, 2'd2, 0, 32'(i * 4), $urandom, rd, e);
            applyStimulus(1, 1, 2'd2, 0, 32'(i * 4), $urandom, rd, e);
        end

        // Word store then load.
        applyStimulus(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, rd, e);
        applyStimulus(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, e);
        checkOutput("wordLoad", rd, 32'hDEADBEEF);

        // Byte and half lanes.
        applyStimulus(0, 1, 2'd2, 0, 32'h20, 32'h11223344, rd, e);
        applyStimulus(0, 1, 2'd0, 0, 32'h21, 32'hFFFFFFAA, rd, e);
        applyStimulus(0, 1, 2'd1, 0, 32'h22, 32'h1234BBCC, rd, e);
        applyStimulus(0, 0, 2'd2, 0, 32'h20, 32'h0, rd, e);
        checkOutput("laneMerge", rd, 32'hBBCCAA44);

        // Extension.
        applyStimulus(0, 1, 2'd2, 0, 32'h30, 32'h80FF7F01, rd, e);
        applyStimulus(0, 0, 2'd0, 0, 32'h32, 32'h0, rd, e);
        checkOutput("ldByteS", rd, 32'hFFFFFFFF);
        applyStimulus(0, 0, 2'd0, 1, 32'h33, 32'h0, rd, e);
        checkOutput("ldByteU", rd, 32'h00000080);
        applyStimulus(0, 0, 2'd1, 0, 32'h30, 32'h0, rd, e);
        checkOutput("ldHalfLo", rd, 32'h00007F01);
        applyStimulus(0, 0, 2'd1, 0, 32'h32, 32'h0, rd, e);
        checkOutput("ldHalfHi", rd, 32'hFFFF80FF);

        // Faults.
        applyStimulus(0, 1, 2'd2, 0, 32'h40, 32'hCAFEF00D, rd, e);
        applyStimulus(0, 1, 2'd2, 0, 32'h00, 32'h0BADC0DE, rd, e);
        applyStimulus(0, 0, 2'd1, 0, 32'h31, 32'h0, rd, e);
        checkOutput("fHalfErr", e, 1); checkOutput("fHalfRd", rd, 0);
        applyStimulus(0, 1, 2'd2, 0, 32'h42, 32'h12345678, rd, e);
        checkOutput("fWordErr", e, 1);
        applyStimulus(0, 1, 2'd3, 0, 32'h30, 32'h12345678, rd, e);
        checkOutput("fSizeErr", e, 1);
        applyStimulus(0, 1, 2'd2, 0, 32'h400, 32'h55555555, rd, e);
        checkOutput("fRangeErr", e, 1);
        applyStimulus(0, 0, 2'd2, 0, 32'h40, 32'h0, rd, e);
        checkOutput("fKeep40", rd, 32'hCAFEF00D);
        applyStimulus(0, 0, 2'd2, 0, 32'h30, 32'h0, rd, e);
        checkOutput("fKeep30", rd, 32'h80FF7F01);
        applyStimulus(0, 0, 2'd2, 0, 32'h00, 32'h0, rd, e);
        checkOutput("fKeep00", rd, 32'h0BADC0DE);

        // Mid-cycle asynchronous reset on the LATENCY=1 instance.
        applyStimulus(0, 0, 2'd2, 0, 32'h10, 32'h0, rd, e);
        @(posedge clk);
        #3 rstA = 1'b1;
        #1;
        checkOutput("asyncReady", readyA, 1); checkOutput("asyncDone", doneA, 0);
        checkOutput("asyncErr", errA, 0);     checkOutput("asyncRd", rdA, 0);
        @(negedge clk);
        rstA = 1'b0;

        for (int i = 0; i < 200; i++) randomAccess(0);

        // LATENCY=3 handshake and abort.
        applyStimulus(1, 1, 2'd2, 0, 32'h08, 32'h13579BDF, rd, e);
        applyStimulus(1, 0, 2'd2, 0, 32'h08, 32'h0, rd, e);
        checkOutput("bWord", rd, 32'h13579BDF);
        @(negedge clk);
        weI = 1'b1; sizeI = 2'd2; unsI = 1'b0; addrI = 32'h08; wdataI = 32'h2468ACE0;
        reqB = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reqB = 1'b0;
        checkOutput("abortBusy", readyB, 0);
        #1 rstB = 1'b1;
        #2 checkOutput("abortReady", readyB, 1);
        @(negedge clk);
        rstB = 1'b0;
        applyStimulus(1, 0, 2'd2, 0, 32'h08, 32'h0, rd, e);
        checkOutput("abortKeep", rd, 32'h13579BDF);

        for (int i = 0; i < 40; i++) randomAccess(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_mem_sized.md
Name: data_mem_sized

Overview:
- Byte-addressed, word-organised data memory for the MIPS datapath, the next generation of the single-cycle data memory.
- Adds byte, halfword and word loads/stores with sign or zero extension, plus byte-lane write masking.
- Adds a req/ready/done handshake with a parametrised access latency, so the pipeline can be stalled by memory.
- Detects misaligned, out-of-range and reserved-size accesses and reports them instead of corrupting memory.

Parameters:
- ADDR_SIZE, 256: number of 32-bit words in the array.
- ADDR_WIDTH, 32: byte-address width; must satisfy ADDR_WIDTH >= clog2(ADDR_SIZE)+2.
- DATA_WIDTH, 32: data width; fixed at 32 (4 byte lanes), elaboration error otherwise.
- LATENCY, 1: cycles from the accept edge to done; must be >= 1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- req  input  1  access request
- write_en  input  1  1 = store, 0 = load; sampled with req
- size  input  2  00 byte, 01 half, 10 word, 11 reserved
- unsigned_ld  input  1  1 = zero-extend loads, 0 = sign-extend
- addr  input  ADDR_WIDTH  byte address
- write_data  input  DATA_WIDTH  store data, right-justified (byte in [7:0], half in [15:0])
- ready  output  1  block can accept a request this cycle
- done  output  1  one-cycle completion pulse
- read_data  output  DATA_WIDTH  extended load result, valid while done=1
- err  output  1  access faulted, valid while done=1

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, ready=1, done=0, err=0, read_data=0, wait counter=0.
  - Memory array contents are not reset.
- Accept: a request is accepted on a rising clk edge with req=1 and ready=1.
  - On accept, latch addr, size, write_en, unsigned_ld and write_data.
  - While ready=0, req is ignored and not queued.
- States:
  - IDLE: ready=1. On accept go to BUSY with count=LATENCY-1; if LATENCY=1 go directly to DONE.
  - BUSY: ready=0. Decrement count each cycle; go to DONE when count=0.
  - DONE: ready=0, done=1 for exactly one cycle, then IDLE.
- Timing: done is high in the cycle LATENCY edges after the accept edge. Throughput is one access per LATENCY+1 cycles.
- Fault checks, evaluated on latched values:
  - size=11 is a fault.
  - Half access with addr[0]=1 is a fault.
  - Word access with addr[1:0]!=0 is a fault.
  - Word index addr[ADDR_WIDTH-1:2] >= ADDR_SIZE is a fault.
  - A faulting access still follows the full FSM timing, reports done=1 and err=1 with read_data=0, and leaves memory unchanged.
- Store commit: a store writes on the same edge that enters DONE (ordinary single edge).
  - Byte store: write lane addr[1:0] with write_data[7:0]. Other lanes are untouched.
  - Half store: write lanes {addr[1],1'b1..addr[1],1'b0}, i.e. bytes 2*addr[1] and 2*addr[1]+1, with write_data[15:0], little-endian (low byte at lower address).
  - Word store: write all four lanes.
  - read_data=0 in the store's DONE cycle.
- Load: read the word on the edge entering DONE.
  - Byte load: select byte addr[1:0].
  - Half load: select half addr[1].
  - Extend to 32 bits: sign-extend when unsigned_ld=0, zero-extend when unsigned_ld=1. unsigned_ld is ignored for word loads.
- read_data and err hold their values after done falls, until the next DONE cycle or reset.
- Reset mid-operation: any access in BUSY is aborted and its store is never committed. A store whose commit edge coincides with rst assertion is not committed.
- A read after a write to the same word returns the newly written data, since the two accesses are serialised by the handshake.

Test Plan:
- Reset, LATENCY=1: assert rst mid-cycle -> ready=1, done=0, err=0, read_data=0 immediately, without waiting for a clock edge.
- Word store then load: store 0xDEADBEEF to addr 0x10, then load word at 0x10 -> done one cycle after each accept, read_data=0xDEADBEEF, err=0.
- Byte and half lanes: word 0x11223344 at 0x20; byte store 0xAA to 0x21, then half store 0xBBCC to 0x22 -> word load at 0x20 returns 0xBBCCAA44.
- Extension: word 0x80FF7F01 at 0x30. Load byte 0x32 signed -> 0xFFFFFFFF. Load byte 0x33 unsigned -> 0x00000080. Load half 0x30 signed -> 0x00007F01. Load half 0x32 signed -> 0xFFFF80FF.
- Faults: half load at 0x31, word store at 0x42, size=11, and word index=ADDR_SIZE -> each gives done with err=1 and read_data=0, and memory is unchanged on readback.
- LATENCY=3 handshake and abort:
  - Accept at edge 0 -> ready=0 for cycles 1-3, done=1 in cycle 3 only, ready=1 in cycle 4.
  - req held high during BUSY is ignored.
  - A store with rst asserted during BUSY -> the old word is retained.
